// File: rtl/lcd_timing_pkg.sv
// Shared constants, colour-bar table and FSM state type for the LCD timing generator.
package lcd_timing_pkg;

  localparam int unsigned DefHSync   = 20;
  localparam int unsigned DefHBp     = 26;
  localparam int unsigned DefHActive = 800;
  localparam int unsigned DefHFp     = 210;
  localparam int unsigned DefVSync   = 3;
  localparam int unsigned DefVBp     = 20;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 22;
  localparam int unsigned DefHW      = 11;
  localparam int unsigned DefVW      = 10;

  localparam int unsigned RW   = 5;
  localparam int unsigned GW   = 6;
  localparam int unsigned BW   = 5;
  localparam int unsigned RgbW = RW + GW + BW;

  localparam int unsigned NumBars = 8;

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [RgbW-1:0] BarColors [NumBars] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  function automatic logic [RgbW-1:0] bar_color(logic [2:0] idx);
    return BarColors[idx];
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Pixel-source handshake and LCD pin bundle for lcd_timing_gen.
interface lcd_timing_gen_if
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_W = DefHW,
  parameter int unsigned V_W = DefVW
) ();

  logic            run;
  logic            pix_req;
  logic [H_W-1:0]  pix_x;
  logic [V_W-1:0]  pix_y;
  logic [RgbW-1:0] rgb_in;
  logic            lcd_de;
  logic            lcd_hsync;
  logic            lcd_vsync;
  logic [RW-1:0]   lcd_r;
  logic [GW-1:0]   lcd_g;
  logic [BW-1:0]   lcd_b;
  logic            frame_start;
  logic            busy;

  modport master (
    input  run, rgb_in,
    output pix_req, pix_x, pix_y, lcd_de, lcd_hsync, lcd_vsync,
    output lcd_r, lcd_g, lcd_b, frame_start, busy
  );

  modport slave (
    output run, rgb_in,
    input  pix_req, pix_x, pix_y, lcd_de, lcd_hsync, lcd_vsync,
    input  lcd_r, lcd_g, lcd_b, frame_start, busy
  );

endinterface

// File: rtl/lcd_color_bar.sv
// Eight-band vertical colour bar, combinational from active-area column to RGB565.
module lcd_color_bar
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_W      = DefHW,
  parameter int unsigned H_ACTIVE = DefHActive
) (
  input  logic [H_W-1:0]  pix_x_i,
  output logic [RgbW-1:0] rgb_o
);

  localparam logic [H_W-1:0] BandW   = H_W'(H_ACTIVE / NumBars);
  localparam logic [H_W-1:0] LastBar = H_W'(NumBars - 1);

  logic [H_W-1:0] band;

  always_comb begin
    band  = pix_x_i / BandW;
    // Leftover columns when H_ACTIVE is not a multiple of 8 stay in the last band.
    rgb_o = (band > LastBar) ? bar_color(3'd7) : bar_color(band[2:0]);
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// HSYNC/VSYNC/DE generator with a 2-stage pixel pipeline for an RGB565 panel.
// Build with LCD_TIMING_TEST_PATTERN_EN defined to replace rgb_in by an internal colour bar.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned H_W      = DefHW,
  parameter int unsigned V_W      = DefVW
) (
  input  logic             PixelClk,
  input  logic             nRST,
  lcd_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  if (H_TOTAL >= (2 ** H_W) || V_TOTAL >= (2 ** V_W) || H_ACTIVE < NumBars) begin : g_param_err
    $error("lcd_timing_gen: timing totals do not fit H_W/V_W or H_ACTIVE too small");
  end

  localparam logic [H_W-1:0] HSyncEnd = H_W'(H_SYNC);
  localparam logic [H_W-1:0] HActBeg  = H_W'(H_SYNC + H_BP);
  localparam logic [H_W-1:0] HActEnd  = H_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [H_W-1:0] HLast    = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] VSyncEnd = V_W'(V_SYNC);
  localparam logic [V_W-1:0] VActBeg  = V_W'(V_SYNC + V_BP);
  localparam logic [V_W-1:0] VActEnd  = V_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [V_W-1:0] VLast    = V_W'(V_TOTAL - 1);

  state_e          state_q;
  logic [H_W-1:0]  h_q;
  logic [V_W-1:0]  v_q;
  logic            busy_q;

  logic            last_h, last_v, active, h_act, v_act;
  logic            de0, hs0, vs0, fs0;
  logic [H_W-1:0]  pix_x;
  logic [V_W-1:0]  pix_y;
  logic [RgbW-1:0] pix_src;

  logic            de1_q, hs1_q, vs1_q, fs1_q;
  logic            lcd_de_q, lcd_hsync_q, lcd_vsync_q, fs_q;
  logic [RgbW-1:0] rgb_q;

  // Stage 0: decode the counters.
  always_comb begin
    last_h = (h_q == HLast);
    last_v = (v_q == VLast);
    active = (state_q != StIdle);
    h_act  = (h_q >= HActBeg) && (h_q < HActEnd);
    v_act  = (v_q >= VActBeg) && (v_q < VActEnd);
    de0    = active && h_act && v_act;
    hs0    = active && (h_q < HSyncEnd);
    vs0    = active && (v_q < VSyncEnd);
    fs0    = (state_q == StRun) && (h_q == '0) && (v_q == '0);
    pix_x  = de0 ? (h_q - HActBeg) : '0;
    pix_y  = de0 ? (v_q - VActBeg) : '0;
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          h_q <= '0;
          v_q <= '0;
          if (bus.run) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun, StDrain: begin
          // Stopping at the frame end skips DRAIN so no headless frame is started.
          if (!bus.run && last_h && last_v) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
          end else begin
            state_q <= bus.run ? StRun : StDrain;
            busy_q  <= 1'b1;
            if (last_h) begin
              h_q <= '0;
              v_q <= last_v ? '0 : v_q + 1'b1;
            end else begin
              h_q <= h_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          h_q     <= '0;
          v_q     <= '0;
        end
      endcase
    end
  end

`ifdef LCD_TIMING_TEST_PATTERN_EN
  logic [RgbW-1:0] bar_rgb;
  logic [RgbW-1:0] bar1_q;

  lcd_color_bar #(
    .H_W      (H_W),
    .H_ACTIVE (H_ACTIVE)
  ) u_color_bar (
    .pix_x_i (pix_x),
    .rgb_o   (bar_rgb)
  );

  // Registered alongside de1 so it lines up with where rgb_in would arrive.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      bar1_q <= '0;
    end else begin
      bar1_q <= bar_rgb;
    end
  end

  assign pix_src = bar1_q;
`else
  assign pix_src = bus.rgb_in;
`endif

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      de1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      fs1_q       <= 1'b0;
      lcd_de_q    <= 1'b0;
      lcd_hsync_q <= ~HS_POL;
      lcd_vsync_q <= ~VS_POL;
      fs_q        <= 1'b0;
      rgb_q       <= '0;
    end else begin
      de1_q       <= de0;
      hs1_q       <= hs0;
      vs1_q       <= vs0;
      fs1_q       <= fs0;
      lcd_de_q    <= de1_q;
      lcd_hsync_q <= hs1_q ? HS_POL : ~HS_POL;
      lcd_vsync_q <= vs1_q ? VS_POL : ~VS_POL;
      fs_q        <= fs1_q;
      // Upstream answers pix_req one cycle later, i.e. while de1 is set.
      rgb_q       <= de1_q ? pix_src : '0;
    end
  end

  assign bus.pix_req     = de0;
  assign bus.pix_x       = pix_x;
  assign bus.pix_y       = pix_y;
  assign bus.lcd_de      = lcd_de_q;
  assign bus.lcd_hsync   = lcd_hsync_q;
  assign bus.lcd_vsync   = lcd_vsync_q;
  assign bus.lcd_r       = rgb_q[RgbW-1 -: RW];
  assign bus.lcd_g       = rgb_q[BW +: GW];
  assign bus.lcd_b       = rgb_q[BW-1:0];
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen with shrunken timing; frame position tracked as a linear index.
module tb_lcd_timing_gen;

  localparam int unsigned HS = 4, HB = 3, HA = 16, HF = 5;
  localparam int unsigned VS = 2, VB = 2, VA = 6, VF = 2;
  localparam int unsigned HT = HS + HB + HA + HF;
  localparam int unsigned VT = VS + VB + VA + VF;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned LAT = 2;

  typedef struct packed {
    logic        act;
    logic [31:0] pos;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_timing_gen_if #(.H_W(11), .V_W(10)) bus ();

  lcd_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .H_W(11), .V_W(10)
  ) dut (
    .PixelClk (clk),
    .nRST     (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int last_fs_cyc = 0;
  mstate_t m0, m1, m2;

  function automatic int unsigned mh(mstate_t s); return s.pos % HT; endfunction
  function automatic int unsigned mv(mstate_t s); return s.pos / HT; endfunction
  function automatic int unsigned mx(mstate_t s); return mh(s) - (HS + HB); endfunction
  function automatic int unsigned my(mstate_t s); return mv(s) - (VS + VB); endfunction
  function automatic logic m_de(mstate_t s);
    return s.act && mh(s) >= HS + HB && mh(s) < HS + HB + HA
                 && mv(s) >= VS + VB && mv(s) < VS + VB + VA;
  endfunction
  function automatic logic m_hs(mstate_t s); return s.act && mh(s) < HS; endfunction
  function automatic logic m_vs(mstate_t s); return s.act && mv(s) < VS; endfunction

  function automatic logic [15:0] px_val(int unsigned x, int unsigned y);
    logic [10:0] xv;
    logic [9:0]  yv;
    xv = 11'(x);
    yv = 10'(y);
    return {yv[4:0], xv[5:0], yv[4:0]};
  endfunction

  function automatic mstate_t advance(mstate_t s, logic r);
    mstate_t n;
    n = s;
    if (!s.act) begin
      if (r) begin
        n.act = 1'b1;
        n.pos = '0;
      end
    end else if (s.pos == FRAME - 1 && !r) begin
      n.act = 1'b0;
      n.pos = '0;
    end else begin
      n.pos = (s.pos + 1) % FRAME;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] rgb_obs;
    logic [15:0] rgb_exp;
    rgb_obs = {bus.lcd_r, bus.lcd_g, bus.lcd_b};
    rgb_exp = m_de(m2) ? px_val(mx(m2), my(m2)) : 16'h0000;
    chk("lcd_de", 32'(bus.lcd_de), 32'(m_de(m2)));
    chk("lcd_hsync", 32'(bus.lcd_hsync), 32'(!m_hs(m2)));
    chk("lcd_vsync", 32'(bus.lcd_vsync), 32'(!m_vs(m2)));
    chk("frame_start", 32'(bus.frame_start), 32'(m2.act && m2.pos == 0));
    chk("rgb", 32'(rgb_obs), 32'(rgb_exp));
    chk("busy", 32'(bus.busy), 32'(m0.act));
    chk("pix_req", 32'(bus.pix_req), 32'(m_de(m0)));
    chk("pix_x", 32'(bus.pix_x), m_de(m0) ? mx(m0) : 0);
    chk("pix_y", 32'(bus.pix_y), m_de(m0) ? my(m0) : 0);
    if (m_de(m2) && mx(m2) == 0 && my(m2) == 0) chk("first_px", 32'(rgb_obs), 32'h0000);
    // {5'd5, 6'd15, 5'd5} for the last pixel (15,5) of this geometry.
    if (m_de(m2) && mx(m2) == HA - 1 && my(m2) == VA - 1) chk("last_px", 32'(rgb_obs), 32'h29E5);
  endtask

  // One clock: the upstream model answers the request seen before the edge.
  task automatic cyc();
    logic        req, r;
    logic [10:0] x;
    logic [9:0]  y;
    req = bus.pix_req;
    x = bus.pix_x;
    y = bus.pix_y;
    r = bus.run;
    @(posedge clk);
    #1;
    cyc_n++;
    m2 = m1;
    m1 = m0;
    if (!rst_n) begin
      m0 = '0;
      m1 = '0;
      m2 = '0;
    end else begin
      m0 = advance(m0, r);
    end
    bus.rgb_in = req ? px_val(x, y) : 16'($urandom);
    check_outputs();
    if (bus.frame_start) last_fs_cyc = cyc_n;
  endtask

  task automatic wait_pos(input int unsigned h, input int unsigned v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      cyc();
      found = m0.act && m0.pos == v * HT + h;
    end
    chk("wait_pos", 32'(found), 32'd1);
  endtask

  task automatic wait_fs();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      cyc();
      found = bus.frame_start;
    end
    chk("wait_fs", 32'(found), 32'd1);
  endtask

  task automatic measure_frame();
    int start, de_n, hs_n, vs_n;
    logic found;
    wait_fs();
    start = cyc_n;
    de_n = 0; hs_n = 0; vs_n = 0;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      de_n += int'(bus.lcd_de);
      hs_n += int'(!bus.lcd_hsync);
      vs_n += int'(!bus.lcd_vsync);
      cyc();
      found = bus.frame_start;
    end
    chk("fs_period", 32'(cyc_n - start), FRAME);
    chk("de_per_frame", 32'(de_n), HA * VA);
    chk("hsync_low_per_frame", 32'(hs_n), HS * VT);
    chk("vsync_low_per_frame", 32'(vs_n), VS * HT);
  endtask

  initial begin
    int prev_fs, rel, req_n;
    logic gone;
    m0 = '0; m1 = '0; m2 = '0;
    bus.run = 1'b0;
    bus.rgb_in = '0;

    // Reset held, then released with run low.
    repeat (5) cyc();
    rst_n = 1'b1;
    repeat (100) cyc();

    // Free-running frames.
    bus.run = 1'b1;
    measure_frame();
    measure_frame();

    // Drain: busy falls at the frame end, FRAME-LAT cycles after frame_start reaches the pins.
    wait_pos(0, 3);
    bus.run = 1'b0;
    gone = 1'b0;
    for (int i = 0; i < 2 * FRAME && !gone; i++) begin
      cyc();
      gone = !bus.busy;
    end
    chk("drain_busy_fall", 32'(gone), 32'd1);
    chk("drain_len", 32'(cyc_n - last_fs_cyc), FRAME - LAT);
    req_n = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      req_n += int'(bus.pix_req);
    end
    chk("req_after_drain", 32'(req_n), 32'd0);

    // Resume while draining: the next frame_start keeps its slot.
    bus.run = 1'b1;
    wait_fs();
    prev_fs = last_fs_cyc;
    wait_pos(5, 3);
    bus.run = 1'b0;
    wait_pos(9, 7);
    bus.run = 1'b1;
    wait_fs();
    chk("resume_period", 32'(last_fs_cyc - prev_fs), FRAME);

    // Random run toggling against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) bus.run = ~bus.run;
      cyc();
    end

    // Asynchronous reset mid-frame, checked before any clock edge.
    bus.run = 1'b1;
    wait_pos(12, 7);
    #2;
    rst_n = 1'b0;
    #1;
    m0 = '0; m1 = '0; m2 = '0;
    check_outputs();
    repeat (3) cyc();
    rst_n = 1'b1;
    rel = cyc_n;
    wait_fs();
    chk("fs_after_release", 32'(cyc_n - rel), 1 + LAT);
    measure_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
